// File: rtl/cipher_job_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cipher_job_arbiter                                                |
// | Shares one 24-bit encrypt/decrypt engine between two job requesters.       |
// | Round-robin arbitration on valid/ready, one-cycle engine start pulse,      |
// | bounded wait on the engine's ready level, and a single tagged response     |
// | channel with job/error counters.                                           |
// |                                                                            |
// | Ports:                                                                     |
// |   Clock, Reset (async, active-low)                                         |
// |   req{0,1}_valid/ready/text/key/mode : job request channels                |
// |   rsp_valid/ready/id/text/err         : shared response channel            |
// |   eng_start/ptext/key/mode            : engine control (driven only here)  |
// |   eng_ctext/ready                     : engine result                      |
// |   busy, jobs_done, err_count          : status                             |
// |                                                                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cipher_job_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_text,
  input  logic [23:0] req0_key,
  input  logic        req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_text,
  input  logic [23:0] req1_key,
  input  logic        req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [23:0] rsp_text,
  output logic        rsp_err,
  output logic        eng_start,
  output logic [23:0] eng_ptext,
  output logic [23:0] eng_key,
  output logic        eng_mode,
  input  logic [23:0] eng_ctext,
  input  logic        eng_ready,
  output logic        busy,
  output logic [15:0] jobs_done,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic [15:0] r_timer;
  logic        r_eng_start;
  logic [23:0] r_eng_ptext;
  logic [23:0] r_eng_key;
  logic        r_eng_mode;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [23:0] r_rsp_text;
  logic        r_rsp_err;
  logic        r_busy;
  logic [15:0] r_jobs_done;
  logic [7:0]  r_err_count;

  logic w_grant1;
  logic w_accept;

  // Winner if a job were taken now: a lone requester wins outright, a tie
  // goes to whoever was not served last.
  always_comb begin
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant1 = req1_valid;
    end
  end

  // Reset is folded in so neither ready can show 1 while Reset is held low.
  assign req0_ready = Reset & (r_state == S_IDLE) & req0_valid & ~w_grant1;
  assign req1_ready = Reset & (r_state == S_IDLE) & req1_valid &  w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_timer      <= 16'd0;
      r_eng_start  <= 1'b0;
      r_eng_ptext  <= 24'd0;
      r_eng_key    <= 24'd0;
      r_eng_mode   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_text   <= 24'd0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_jobs_done  <= 16'd0;
      r_err_count  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_eng_ptext  <= w_grant1 ? req1_text : req0_text;
            r_eng_key    <= w_grant1 ? req1_key  : req0_key;
            r_eng_mode   <= w_grant1 ? req1_mode : req0_mode;
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_eng_start  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_eng_start <= 1'b0;
          r_state     <= S_SETTLE;
        end
        S_SETTLE: begin
          // eng_ready may still reflect the previous job here; do not look.
          r_timer <= 16'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_ready) begin
            r_rsp_text  <= eng_ctext;
            r_rsp_err   <= 1'b0;
            r_jobs_done <= r_jobs_done + 16'd1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_timer == c_TIMER_LAST) begin
            r_rsp_text  <= 24'd0;
            r_rsp_err   <= 1'b1;
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_start = r_eng_start;
  assign eng_ptext = r_eng_ptext;
  assign eng_key   = r_eng_key;
  assign eng_mode  = r_eng_mode;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_text  = r_rsp_text;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign jobs_done = r_jobs_done;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_cipher_job_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_cipher_job_arbiter                                             |
// | Self-checking bench for cipher_job_arbiter: table of directed jobs plus    |
// | hand-written sequences for stale ready, timeout, backpressure and reset.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cipher_job_arbiter;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic Reset;

  // Main instance (TIMEOUT 64) with a behavioural engine.
  logic        req0_valid, req0_ready, req0_mode, req1_valid, req1_ready, req1_mode;
  logic [23:0] req0_text, req0_key, req1_text, req1_key;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [23:0] rsp_text;
  logic        eng_start, eng_mode;
  logic [23:0] eng_ptext, eng_key;
  logic [23:0] eng_ctext = 24'd0;
  logic        eng_ready = 1'b0;
  logic        busy;
  logic [15:0] jobs_done;
  logic [7:0]  err_count;

  // Second instance (TIMEOUT 8) with a directly driven engine.
  logic        t_req0_valid, t_req0_ready, t_req0_mode, t_req1_valid, t_req1_ready, t_req1_mode;
  logic [23:0] t_req0_text, t_req0_key, t_req1_text, t_req1_key;
  logic        t_rsp_valid, t_rsp_ready, t_rsp_id, t_rsp_err;
  logic [23:0] t_rsp_text;
  logic        t_eng_start, t_eng_mode;
  logic [23:0] t_eng_ptext, t_eng_key, t_eng_ctext;
  logic        t_eng_ready, t_busy;
  logic [15:0] t_jobs_done;
  logic [7:0]  t_err_count;

  cipher_job_arbiter #(.TIMEOUT(64)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_text(req0_text),
    .req0_key(req0_key), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_text(req1_text),
    .req1_key(req1_key), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_text(rsp_text), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_ptext(eng_ptext), .eng_key(eng_key),
    .eng_mode(eng_mode), .eng_ctext(eng_ctext), .eng_ready(eng_ready),
    .busy(busy), .jobs_done(jobs_done), .err_count(err_count)
  );

  cipher_job_arbiter #(.TIMEOUT(8)) u_dut_to (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_text(t_req0_text),
    .req0_key(t_req0_key), .req0_mode(t_req0_mode),
    .req1_valid(t_req1_valid), .req1_ready(t_req1_ready), .req1_text(t_req1_text),
    .req1_key(t_req1_key), .req1_mode(t_req1_mode),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
    .rsp_text(t_rsp_text), .rsp_err(t_rsp_err),
    .eng_start(t_eng_start), .eng_ptext(t_eng_ptext), .eng_key(t_eng_key),
    .eng_mode(t_eng_mode), .eng_ctext(t_eng_ctext), .eng_ready(t_eng_ready),
    .busy(t_busy), .jobs_done(t_jobs_done), .err_count(t_err_count)
  );

  // Engine model: ready drops after start (or one cycle later in stale mode)
  // and rises m_lat cycles after the start pulse with the computed result.
  int          m_lat = 4;
  bit          m_stale = 1'b0;
  bit          m_force = 1'b0;
  logic [23:0] m_force_val = 24'd0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [23:0] m_res = 24'd0;

  always @(posedge Clock) begin
    if (eng_start) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      m_res  <= m_force ? m_force_val :
                (eng_mode ? ~(eng_ptext ^ eng_key) : (eng_ptext ^ eng_key));
      if (!m_stale) eng_ready <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        eng_ready <= 1'b1;
        eng_ctext <= m_res;
        m_busy    <= 1'b0;
      end else begin
        eng_ready <= 1'b0;
        m_cnt     <= m_cnt - 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    bit          v0, v1;
    logic [23:0] t0, k0;
    bit          m0;
    logic [23:0] t1, k1;
    bit          m1;
    int          lat;
    bit          eid;
    logic [23:0] etext;
  } vec_t;

  // Runs one job on the main instance with rsp_ready high. Valids are left
  // asserted on return so back-to-back jobs see them held continuously.
  task automatic run_job(input vec_t v, output bit got_id, output logic [23:0] got_text,
                         output bit got_err, output int lat_c, output int n_starts,
                         output int op_bad);
    bit g;
    bit acc;
    int w;
    req0_text = v.t0; req0_key = v.k0; req0_mode = v.m0;
    req1_text = v.t1; req1_key = v.k1; req1_mode = v.m1;
    req0_valid = v.v0; req1_valid = v.v1; m_lat = v.lat;
    acc = 1'b0; g = 1'b0; w = 0; lat_c = -1; n_starts = 0; op_bad = 0;
    got_id = 1'b0; got_text = 24'd0; got_err = 1'b0;
    while (!acc && w < 10) begin
      #1;
      if (req0_valid && req0_ready) acc = 1'b1;
      else if (req1_valid && req1_ready) begin acc = 1'b1; g = 1'b1; end
      tick();
      w++;
    end
    if (!acc) begin
      op_bad = 1000;
      return;
    end
    for (int c = 1; c <= 300; c++) begin
      if (eng_start) n_starts++;
      if (c == 1 && !eng_start) op_bad++;
      if (eng_ptext !== (g ? v.t1 : v.t0) || eng_key !== (g ? v.k1 : v.k0) ||
          eng_mode !== (g ? v.m1 : v.m0) || busy !== 1'b1) op_bad++;
      if (rsp_valid) begin
        lat_c = c; got_id = rsp_id; got_text = rsp_text; got_err = rsp_err;
        break;
      end
      tick();
    end
    if (lat_c > 0) tick();
  endtask

  vec_t tbl [9];
  vec_t vj;
  bit          g_id, g_err, acc, s_id, s_err, s_valid;
  logic [23:0] g_text, s_text;
  int          g_lat, g_starts, g_opbad, lat, bp_bad;

  initial begin
    // Reset-ordered contention run: grants 0,1,0,1,0,1, then single requesters.
    tbl[0] = '{1, 1, 24'h111111, 24'h222222, 0, 24'h0F0F0F, 24'h0000F0, 1, 3, 0, 24'h333333};
    tbl[1] = '{1, 1, 24'h111111, 24'h222222, 0, 24'h0F0F0F, 24'h0000F0, 1, 1, 1, 24'hF0F000};
    tbl[2] = '{1, 1, 24'h000001, 24'h000002, 0, 24'hA0A0A0, 24'h0B0B0B, 0, 2, 0, 24'h000003};
    tbl[3] = '{1, 1, 24'h000000, 24'h333333, 1, 24'hAAAAAA, 24'h555555, 0, 7, 1, 24'hFFFFFF};
    tbl[4] = '{1, 1, 24'h123456, 24'h000000, 1, 24'h565656, 24'h121212, 0, 4, 0, 24'hEDCBA9};
    tbl[5] = '{1, 1, 24'h999999, 24'h444444, 1, 24'h0000FF, 24'h0000F0, 0, 2, 1, 24'h00000F};
    tbl[6] = '{0, 1, 24'h999999, 24'h444444, 1, 24'h00FF00, 24'h000000, 0, 1, 1, 24'h00FF00};
    tbl[7] = '{1, 0, 24'h0000FF, 24'h0000FF, 1, 24'h00FF00, 24'h000000, 0, 5, 0, 24'hFFFFFF};
    tbl[8] = '{1, 1, 24'h777777, 24'h777777, 1, 24'h010203, 24'h000000, 0, 1, 1, 24'h010203};

    Reset = 1'b0;
    req0_valid = 1; req1_valid = 1; req0_text = 0; req0_key = 0; req0_mode = 0;
    req1_text = 0; req1_key = 0; req1_mode = 0; rsp_ready = 1;
    t_req0_valid = 0; t_req1_valid = 0; t_req0_text = 0; t_req0_key = 0; t_req0_mode = 0;
    t_req1_text = 0; t_req1_key = 0; t_req1_mode = 0; t_rsp_ready = 1;
    t_eng_ready = 0; t_eng_ctext = 0;
    tick(); tick();

    // Reset state, with both requesters valid.
    check("reset ready", {req0_ready, req1_ready}, 2'b00);
    check("reset outputs", {eng_start, eng_ptext, eng_key, eng_mode, rsp_valid, rsp_id,
                            rsp_text, rsp_err, busy, jobs_done, err_count}, 0);
    req0_valid = 0; req1_valid = 0;
    Reset = 1'b1;
    tick();

    // Single encrypt with a 50-cycle engine.
    m_force = 1; m_force_val = 24'h0F0F0F;
    vj = '{1, 0, 24'h123456, 24'hABCDEF, 0, 24'h0, 24'h0, 0, 49, 0, 24'h0F0F0F};
    run_job(vj, g_id, g_text, g_err, g_lat, g_starts, g_opbad);
    req0_valid = 0;
    m_force = 0;
    check("single starts", g_starts, 1);
    check("single latency", g_lat, 52);
    check("single id", g_id, 0);
    check("single text", g_text, 24'h0F0F0F);
    check("single err", g_err, 0);
    check("single operands", g_opbad, 0);
    check("single jobs_done", jobs_done, 1);

    // Fresh reset so the first tie goes to req0 again.
    Reset = 1'b0; tick();
    check("reset2 jobs_done", jobs_done, 0);
    Reset = 1'b1; tick();

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i], g_id, g_text, g_err, g_lat, g_starts, g_opbad);
      check($sformatf("vec%0d id", i), g_id, tbl[i].eid);
      check($sformatf("vec%0d text", i), g_text, tbl[i].etext);
      check($sformatf("vec%0d err", i), g_err, 0);
      check($sformatf("vec%0d latency", i), g_lat, tbl[i].lat + 3);
      check($sformatf("vec%0d starts", i), g_starts, 1);
      check($sformatf("vec%0d operands", i), g_opbad, 0);
    end
    req0_valid = 0; req1_valid = 0;
    check("table jobs_done", jobs_done, 9);

    // Stale ready: engine keeps ready high into SETTLE with the old result.
    m_stale = 1;
    vj = '{1, 0, 24'h0F0000, 24'h00F000, 0, 24'h0, 24'h0, 0, 5, 0, 24'h0FF000};
    run_job(vj, g_id, g_text, g_err, g_lat, g_starts, g_opbad);
    req0_valid = 0;
    m_stale = 0;
    check("stale latency", g_lat, 8);
    check("stale text", g_text, 24'h0FF000);
    check("stale jobs_done", jobs_done, 10);

    // Backpressure: response held 20 cycles while req1 waits.
    rsp_ready = 0; m_lat = 2;
    req0_text = 24'hABCDEF; req0_key = 24'h000000; req0_mode = 0; req0_valid = 1;
    acc = 0;
    for (int w = 0; w < 10 && !acc; w++) begin #1; acc = req0_ready; tick(); end
    check("bp accept", acc, 1);
    req0_valid = 0;
    req1_text = 24'h111000; req1_key = 24'h000111; req1_mode = 0; req1_valid = 1;
    bp_bad = 0; s_valid = 0;
    for (int c = 0; c < 50 && !s_valid; c++) begin
      if (req1_ready) bp_bad++;
      if (rsp_valid) s_valid = 1; else tick();
    end
    check("bp rsp_valid", s_valid, 1);
    s_id = rsp_id; s_text = rsp_text; s_err = rsp_err;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_text !== s_text ||
          rsp_err !== s_err || req1_ready !== 1'b0) bp_bad++;
      tick();
    end
    check("bp stable", bp_bad, 0);
    check("bp fields", {s_id, s_text, s_err}, {1'b0, 24'hABCDEF, 1'b0});
    rsp_ready = 1;
    #1;
    check("bp handshake ready", req1_ready, 0);
    tick();
    check("bp idle", {busy, rsp_valid, req1_ready}, 3'b001);
    tick();
    req1_valid = 0;
    check("bp req1 busy", busy, 1);
    s_valid = 0;
    for (int c = 0; c < 50 && !s_valid; c++) begin
      if (rsp_valid) s_valid = 1; else tick();
    end
    check("bp req1 rsp", {s_valid, rsp_id, rsp_text, rsp_err}, {1'b1, 1'b1, 24'h111111, 1'b0});
    tick();
    check("bp jobs_done", jobs_done, 12);

    // Timeout on the TIMEOUT=8 instance, engine ready held low.
    t_req0_text = 24'h000001; t_req0_key = 24'h000002; t_req0_valid = 1;
    acc = 0;
    for (int w = 0; w < 10 && !acc; w++) begin #1; acc = t_req0_ready; tick(); end
    t_req0_valid = 0;
    check("to accept", acc, 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (t_rsp_valid) begin lat = c; break; end
      tick();
    end
    check("to latency", lat, 11);
    check("to rsp", {t_rsp_id, t_rsp_text, t_rsp_err}, {1'b0, 24'h000000, 1'b1});
    check("to err_count", t_err_count, 1);
    tick();
    t_eng_ready = 1; t_eng_ctext = 24'h5A5A5A;
    t_req1_text = 24'h000003; t_req1_key = 24'h000004; t_req1_valid = 1;
    acc = 0;
    for (int w = 0; w < 10 && !acc; w++) begin #1; acc = t_req1_ready; tick(); end
    t_req1_valid = 0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (t_rsp_valid) begin lat = c; break; end
      tick();
    end
    check("to next latency", lat, 4);
    check("to next rsp", {t_rsp_id, t_rsp_text, t_rsp_err}, {1'b1, 24'h5A5A5A, 1'b0});
    tick();
    check("to next counters", {t_err_count, t_jobs_done}, {8'd1, 16'd1});

    // Reset asserted asynchronously while waiting on the engine.
    m_lat = 30;
    req0_text = 24'h222222; req0_key = 24'h000000; req0_mode = 0; req0_valid = 1;
    acc = 0;
    for (int w = 0; w < 10 && !acc; w++) begin #1; acc = req0_ready; tick(); end
    req0_valid = 0;
    tick(); tick(); tick();
    check("rst pre busy", {busy, rsp_valid}, 2'b10);
    #2;
    Reset = 1'b0; req0_valid = 1; req1_valid = 1;
    #1;
    check("rst async outputs", {eng_start, eng_ptext, eng_key, eng_mode, rsp_valid, rsp_id,
                                rsp_text, rsp_err, busy, jobs_done, err_count}, 0);
    check("rst async ready", {req0_ready, req1_ready}, 2'b00);
    req0_valid = 0; req1_valid = 0;
    tick();
    Reset = 1'b1;
    bp_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bp_bad++;
      tick();
    end
    check("rst no response", bp_bad, 0);
    vj = '{1, 1, 24'h00000F, 24'h0000F0, 0, 24'h0000AA, 24'h000055, 0, 2, 0, 24'h0000FF};
    run_job(vj, g_id, g_text, g_err, g_lat, g_starts, g_opbad);
    req0_valid = 0; req1_valid = 0;
    check("rst tie id", g_id, 0);
    check("rst tie text", g_text, 24'h0000FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cipher_job_arbiter.md
# cipher_job_arbiter

Two-port round-robin arbiter and sequencer that shares one 24-bit encrypt/decrypt engine between two requesters. It accepts jobs (text, key, mode) over valid/ready handshakes and pulses the engine's start input. It waits for the engine's ready with a bounded timeout, then returns the result, tagged with the requester ID, on a single shared response channel. It sits between the host-side job sources and the cipher engine, and it is the only block that drives the engine's control inputs.

## Interface
- TIMEOUT, 64: max WAIT-state cycles before a job is aborted; legal range 4..65535
- Clock  in  1  clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low
- req0_valid / req1_valid  in  1  requester N has a job
- req0_ready / req1_ready  out  1  arbiter accepts requester N's job this cycle
- req0_text / req1_text  in  24  plaintext (mode 0) or ciphertext (mode 1)
- req0_key / req1_key  in  24  key
- req0_mode / req1_mode  in  1  0 = encrypt, 1 = decrypt
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the job
- rsp_text  out  24  engine result; 0 on error
- rsp_err  out  1  job timed out
- eng_start  out  1  one-cycle start pulse to engine
- eng_ptext, eng_key  out  24  job operands, held stable for the whole job
- eng_mode  out  1  job mode, held stable for the whole job
- eng_ctext  in  24  engine result
- eng_ready  in  1  engine done, level signal
- busy  out  1  state is not IDLE
- jobs_done  out  16  count of completed non-error responses; wraps
- err_count  out  8  count of timed-out jobs; saturates at 255

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE, arbitration:
  - The grant goes to the single valid requester.
  - If both are valid, the grant goes to the one not equal to last_grant.
  - last_grant resets to 1, so req0 wins the first tie.
  - Only the granted reqN_ready is 1. Both are 0 in every other state and while Reset is low.
- Accept (reqN_valid & reqN_ready):
  - Register text/key/mode into eng_ptext/eng_key/eng_mode.
  - Set rsp_id = N and last_grant = N.
  - Go to ISSUE.
- ISSUE: eng_start = 1 for exactly this cycle, then go to SETTLE.
- SETTLE: eng_start = 0. eng_ready is ignored because it may still show the previous job's level. Go to WAIT and clear the timer.
- WAIT: the timer increments each cycle.
  - If eng_ready = 1: rsp_text = eng_ctext, rsp_err = 0, jobs_done += 1, go to RESP.
  - Else if timer == TIMEOUT-1: rsp_text = 0, rsp_err = 1, err_count += 1 (saturating), go to RESP.
  - eng_ready has priority over timeout in the same cycle.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_text and rsp_err are held stable.
  - On rsp_ready go to IDLE. No new job is accepted in that cycle.
- eng_ptext, eng_key and eng_mode change only on accept. They are never modified during ISSUE through RESP.
- After a timeout the engine may still be running. The next eng_start restarts it; no extra flush is needed.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1.
  - All outputs 0: eng_start, eng_ptext, eng_key, eng_mode, rsp_valid, rsp_id, rsp_text, rsp_err, busy, jobs_done, err_count, req*_ready.
- Reset asserted mid-job: the job is dropped with no response and no counter update, and eng_start drops immediately.
- Accept edge at cycle 0:
  - eng_start is high in cycle 1.
  - SETTLE is cycle 2.
  - WAIT begins in cycle 3.
  - If eng_ready is seen in WAIT cycle k, rsp_valid rises the following cycle.
- Timeout: rsp_valid rises 3 + TIMEOUT cycles after the accept edge.
- Minimum job-to-job spacing: 5 cycles (accept, ISSUE, SETTLE, WAIT, RESP with rsp_ready already high).
- busy = 1 from the cycle after accept until the cycle after the RESP handshake.

## Test plan
- Single encrypt: req0 with text 0x123456, key 0xABCDEF, mode 0, engine model ready after 50 cycles returning 0x0F0F0F. Required: one eng_start pulse, rsp_valid 1 cycle later, rsp_id 0, rsp_text 0x0F0F0F, rsp_err 0, jobs_done 1.
- Contention: req0 and req1 held valid continuously for 6 jobs. Required: grants alternate 0,1,0,1,0,1. eng_key and eng_mode match the granted requester for the whole job.
- Stale ready: the model holds eng_ready = 1 from the previous job until 1 cycle after eng_start. Required: no early completion; the response carries the new job's result.
- Timeout with TIMEOUT = 8 and eng_ready held 0. Required: rsp_valid 11 cycles after accept, rsp_err 1, rsp_text 0, err_count 1; the next job runs normally.
- Backpressure: rsp_ready held 0 for 20 cycles while req1 is valid. Required: rsp fields stable, req1_ready 0 throughout, req1 accepted only after the handshake.
- Reset asserted in WAIT. Required: all outputs 0 asynchronously, no response after release, and req0 wins the first tie after reset.
